pipe_reg_chain: RTL and testbench

Parametrised register pipeline that generalises the single D flip-flop into a DEPTH-stage, WIDTH-bit chain with per-stage valid bits, valid/ready flow control, synchronous flush and an occupancy count. It is the standard delay/retiming element between FPGA datapath blocks where fixed latency or backpressure tolerance is needed. Two modes are supported: lock-step shift with stall, or elastic with bubble collapse.

---
 rtl/pipe_reg_chain_pkg.sv | 13 +
 rtl/pipe_reg_chain_stage.sv | 45 ++++
 rtl/pipe_reg_chain.sv | 130 +++++++++++++
 tb/tb_pipe_reg_chain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// pipe_pkg: shared constants for the register pipeline.
//   PIPE_LOCKSTEP / PIPE_ELASTIC : values for the MODE parameter of pipe_reg_chain
//   count_width()                : bits needed to hold an occupancy of 0..depth
package pipe_pkg;

    localparam int PIPE_LOCKSTEP = 0;
    localparam int PIPE_ELASTIC  = 1;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one pipeline stage, a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears valid; clears data
//                too when RESET_DATA != 0)
//   clr        : synchronous clear of the valid bit only (data kept)
//   load       : capture valid_in/data_in this cycle
//   valid_in   : valid bit of the source (previous stage or chain input)
//   data_in    : data of the source
//   valid      : registered valid bit
//   data       : registered data word
module pipe_stage #(
    parameter int WIDTH      = 8,
    parameter int RESET_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
        end
    end

    // The data register only changes on a load; a clear leaves it alone so a
    // flush costs no data-path toggling.
    always_ff @(posedge clk) begin
        if (rst && (RESET_DATA != 0)) begin
            data <= '0;
        end else if (load) begin
            data <= data_in;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage, WIDTH-bit register pipeline with per-stage valid
// bits, valid/ready flow control, synchronous flush and an occupancy count.
//   MODE = PIPE_LOCKSTEP : all stages shift together whenever the last stage can
//                          move; bubbles are kept, latency is fixed.
//   MODE = PIPE_ELASTIC  : each stage moves when it or anything downstream of it
//                          has room; bubbles collapse under stall.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   flush                : clear all valid bits and the count (data kept)
//   in_valid/in_data     : upstream word
//   in_ready             : chain accepts the upstream word this cycle
//   out_valid/out_data   : word held in the last stage
//   out_ready            : downstream accepts the output word this cycle
//   count                : number of valid stages
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both 1. valid does not depend on ready; ready is a combinational
// function of out_ready and the stage valid bits (no skid buffer), so out_ready
// reaches in_ready in the same cycle.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int MODE       = PIPE_ELASTIC,
    parameter int RESET_DATA = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_reg_chain: WIDTH must be at least 1");
    end
    if ((MODE != PIPE_LOCKSTEP) && (MODE != PIPE_ELASTIC)) begin : g_bad_mode
        $error("pipe_reg_chain: MODE must be PIPE_LOCKSTEP or PIPE_ELASTIC");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_fire;
    logic             out_fire;

    if (MODE == PIPE_LOCKSTEP) begin : g_lockstep
        logic adv;
        assign adv = !v[DEPTH-1] || out_ready;
        assign rdy = {DEPTH{adv}};
    end else begin : g_elastic
        // rdy[i] = !v[i] | rdy[i+1] unrolled: stage i can move when out_ready
        // is high or any stage from i to the output is empty. Written this way
        // so no bit of rdy is computed from another bit of rdy.
        always_comb begin
            rdy = '0;
            for (int i = 0; i < DEPTH; i++) begin
                logic acc;
                acc = out_ready;
                for (int j = i; j < DEPTH; j++) begin
                    acc = acc || !v[j];
                end
                rdy[i] = acc;
            end
        end
    end

    // Nothing loads during reset or flush; that is what keeps the input word
    // of a flush cycle out of the chain.
    assign load     = rdy & {DEPTH{!(rst || flush)}};
    assign in_ready = load[0];
    assign in_fire  = in_valid && in_ready;

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_fire  = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        if (i == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = v[i-1];
            assign src_d = d[i-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .load     (load[i]),
            .valid_in (src_v),
            .data_in  (src_d),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    // in_fire and out_fire together leave the count unchanged. A word leaving
    // on a flush cycle is still delivered; the count is cleared regardless.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + ONE;
        end else if (!in_fire && out_fire) begin
            count <= count - ONE;
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed bench for pipe_reg_chain. Three instances share
// clk/rst: a DEPTH=4 elastic chain (e_*) and a DEPTH=4 lockstep chain (l_*) that
// receive identical input stimulus, and a DEPTH=1 elastic chain with
// RESET_DATA=0 (s_*) driven on its own.
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    localparam int W   = 8;
    localparam int D4  = 4;
    localparam int CW4 = $clog2(D4 + 1);

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared inputs of the two DEPTH=4 chains
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic           e_in_ready, e_out_valid, l_in_ready, l_out_valid;
    logic [W-1:0]   e_out_data, l_out_data;
    logic [CW4-1:0] e_count, l_count;

    // DEPTH=1 chain
    logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [0:0]   s_count;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D4), .MODE(PIPE_ELASTIC), .RESET_DATA(1)) u_el (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(e_in_ready), .out_valid(e_out_valid), .out_data(e_out_data),
        .out_ready(out_ready), .count(e_count)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D4), .MODE(PIPE_LOCKSTEP), .RESET_DATA(1)) u_ls (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_in_ready), .out_valid(l_out_valid), .out_data(l_out_data),
        .out_ready(out_ready), .count(l_count)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(1), .MODE(PIPE_ELASTIC), .RESET_DATA(0)) u_d1 (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .count(s_count)
    );

    // scoreboard state
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e_cnt_m = 0;
    int l_cnt_m = 0;
    int s_cnt_m = 0;
    bit lat_chk = 1'b0;
    logic [W-1:0] e_q[$];
    logic [W-1:0] l_q[$];
    logic [W-1:0] s_q[$];
    int e_t[$];
    int l_t[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the DEPTH=4 pair: inputs are already set by the caller.
    task automatic tick();
        logic         e_if, e_of, l_if, l_of;
        logic [W-1:0] exp_d;
        int           t0;
        #1;
        check("e_count", 32'(e_count), 32'(e_cnt_m));
        check("l_count", 32'(l_count), 32'(l_cnt_m));
        e_if = in_valid && e_in_ready;
        e_of = e_out_valid && out_ready;
        l_if = in_valid && l_in_ready;
        l_of = l_out_valid && out_ready;
        if (e_of) begin
            if (e_q.size() == 0) begin
                check("e_unexp_out", 32'(e_out_valid), 32'd0);
            end else begin
                exp_d = e_q.pop_front();
                t0 = e_t.pop_front();
                check("e_data", 32'(e_out_data), 32'(exp_d));
                if (lat_chk) check("e_latency", 32'(cyc - t0), 32'(D4));
            end
        end
        if (l_of) begin
            if (l_q.size() == 0) begin
                check("l_unexp_out", 32'(l_out_valid), 32'd0);
            end else begin
                exp_d = l_q.pop_front();
                t0 = l_t.pop_front();
                check("l_data", 32'(l_out_data), 32'(exp_d));
                if (lat_chk) check("l_latency", 32'(cyc - t0), 32'(D4));
            end
        end
        if (e_if) begin e_q.push_back(in_data); e_t.push_back(cyc); end
        if (l_if) begin l_q.push_back(in_data); l_t.push_back(cyc); end
        if (flush) begin
            e_cnt_m = 0; l_cnt_m = 0;
            e_q.delete(); e_t.delete(); l_q.delete(); l_t.delete();
        end else begin
            e_cnt_m = e_cnt_m + int'(e_if) - int'(e_of);
            l_cnt_m = l_cnt_m + int'(l_if) - int'(l_of);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         s_if, s_of;
        logic [W-1:0] exp_d;

        // ---------------- reset: 3 cycles with input offered ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_e_out_valid", 32'(e_out_valid), 32'd0);
            check("rst_e_count",     32'(e_count),     32'd0);
            check("rst_e_in_ready",  32'(e_in_ready),  32'd0);
            check("rst_e_out_data",  32'(e_out_data),  32'd0);
            check("rst_l_out_valid", 32'(l_out_valid), 32'd0);
            check("rst_l_in_ready",  32'(l_in_ready),  32'd0);
            check("rst_l_out_data",  32'(l_out_data),  32'd0);
            check("rst_s_out_valid", 32'(s_out_valid), 32'd0);
            check("rst_s_count",     32'(s_count),     32'd0);
            check("rst_s_in_ready",  32'(s_in_ready),  32'd0);
        end
        rst = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        #1;
        check("post_rst_e_in_ready", 32'(e_in_ready), 32'd1);
        check("post_rst_l_in_ready", 32'(l_in_ready), 32'd1);
        check("post_rst_s_in_ready", 32'(s_in_ready), 32'd1);

        // ---------------- streaming 0x01..0x10, out_ready=1 ----------------
        lat_chk = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = W'(k + 1);
            if (k >= 4) begin
                check("stream_e_count", 32'(e_count), 32'd4);
                check("stream_l_count", 32'(l_count), 32'd4);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("stream_e_drained", 32'(e_q.size()), 32'd0);
        check("stream_l_drained", 32'(l_q.size()), 32'd0);

        // ---------------- stall: A1, bubble, A2 with out_ready=0 ----------------
        lat_chk = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_valid = 1'b0;                  tick();
        in_valid = 1'b1; in_data = 8'hA2; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #1;
        check("stall_e_count",     32'(e_count),     32'd2);
        check("stall_e_in_ready",  32'(e_in_ready),  32'd1);
        check("stall_e_out_valid", 32'(e_out_valid), 32'd1);
        check("stall_e_out_data",  32'(e_out_data),  32'hA1);
        check("stall_l_count",     32'(l_count),     32'd2);
        check("stall_l_in_ready",  32'(l_in_ready),  32'd0);
        check("stall_l_out_data",  32'(l_out_data),  32'hA1);
        in_valid = 1'b1; in_data = 8'hA3; #1;
        check("fill_e_ready_a3", 32'(e_in_ready), 32'd1);
        tick();
        in_data = 8'hA4; #1;
        check("fill_e_ready_a4", 32'(e_in_ready), 32'd1);
        tick();
        in_data = 8'hA5; #1;
        check("full_e_in_ready", 32'(e_in_ready), 32'd0);
        check("full_e_count",    32'(e_count),    32'd4);
        check("full_l_in_ready", 32'(l_in_ready), 32'd0);
        tick();
        // release
        in_valid = 1'b0; out_ready = 1'b1; #1;
        check("full_e_ready_follows", 32'(e_in_ready), 32'd1);
        check("rel_l_out_valid0", 32'(l_out_valid), 32'd1);
        check("rel_l_out_data0",  32'(l_out_data),  32'hA1);
        tick();
        check("rel_l_bubble", 32'(l_out_valid), 32'd0);
        tick();
        check("rel_l_out_valid2", 32'(l_out_valid), 32'd1);
        check("rel_l_out_data2",  32'(l_out_data),  32'hA2);
        for (int k = 0; k < 5; k++) tick();
        check("stall_e_drained", 32'(e_q.size()), 32'd0);
        check("stall_l_drained", 32'(l_q.size()), 32'd0);

        // ---------------- flush with full chain and input offered ----------------
        lat_chk = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = W'(8'h30 + k); tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; #1;
        check("flush_e_in_ready", 32'(e_in_ready), 32'd0);
        check("flush_l_in_ready", 32'(l_in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("post_flush_e_out_valid", 32'(e_out_valid), 32'd0);
        check("post_flush_e_count",     32'(e_count),     32'd0);
        check("post_flush_l_out_valid", 32'(l_out_valid), 32'd0);
        check("post_flush_l_count",     32'(l_count),     32'd0);
        for (int k = 0; k < 6; k++) begin
            check("flush_e_quiet", 32'(e_out_valid), 32'd0);
            check("flush_l_quiet", 32'(l_out_valid), 32'd0);
            tick();
        end
        out_ready = 1'b0;

        // ---------------- DEPTH=1 random valid/ready ----------------
        for (int n = 0; n < 10000; n++) begin
            s_in_valid  = 1'($urandom_range(0, 1));
            s_in_data   = W'($urandom_range(0, 255));
            s_out_ready = 1'($urandom_range(0, 1));
            s_flush     = ($urandom_range(0, 63) == 0);
            #1;
            check("d1_count",     32'(s_count),     32'(s_cnt_m));
            check("d1_out_valid", 32'(s_out_valid), 32'(s_cnt_m == 1));
            check("d1_in_ready",  32'(s_in_ready),
                  32'(!s_flush && (s_cnt_m == 0 || s_out_ready)));
            s_if = s_in_valid && s_in_ready;
            s_of = s_out_valid && s_out_ready;
            if (s_of) begin
                if (s_q.size() == 0) begin
                    check("d1_unexp_out", 32'(s_out_valid), 32'd0);
                end else begin
                    exp_d = s_q.pop_front();
                    check("d1_data", 32'(s_out_data), 32'(exp_d));
                end
            end
            if (s_if) s_q.push_back(s_in_data);
            if (s_flush) begin
                s_cnt_m = 0;
                s_q.delete();
            end else begin
                s_cnt_m = s_cnt_m + int'(s_if) - int'(s_of);
            end
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
        #1;
        if (s_out_valid && s_q.size() != 0) begin
            exp_d = s_q.pop_front();
            check("d1_drain_data", 32'(s_out_data), 32'(exp_d));
        end
        @(posedge clk);
        #1;
        check("d1_drained_valid", 32'(s_out_valid), 32'd0);
        check("d1_drained_q",     32'(s_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
